// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler and long-unit scoreboard.
// Ports: issue (iss_*, stall), pipe wb (pipe_*), long unit (lu_*), regfile (rf_*).
module rf_wb_sched #(
  parameter int unsigned MAX_PEND   = 4,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iss_valid,
  input  logic [4:0]  iss_ra,
  input  logic [4:0]  iss_rb,
  input  logic [4:0]  iss_rd,
  input  logic        iss_long,
  output logic        stall,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_di,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_di,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_di
);

  localparam int unsigned PW = 4;
  localparam int unsigned CW = $clog2(STARVE_LIM + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  logic [31:0]   busy_q, busy_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    st_q, st_d;

  logic pipe_act;
  logic commit;
  logic fire;
  logic lng_fire;
  logic hazard;
  logic at_lim;
  logic denied;

  assign pipe_act = pipe_we & (pipe_rd != 5'd0);

  always_comb begin
    if (pipe_act) begin
      lu_ready = 1'b0;
      rf_we    = 1'b1;
      rf_rd    = pipe_rd;
      rf_di    = pipe_di;
    end else begin
      lu_ready = 1'b1;
      rf_we    = lu_valid;
      rf_rd    = lu_rd;
      rf_di    = lu_di;
    end
  end

  assign commit = lu_valid & lu_ready;
  assign denied = lu_valid & ~lu_ready;

  assign hazard = busy_q[iss_ra]
                | busy_q[iss_rb]
                | busy_q[iss_rd];

  assign at_lim = (pend_q == PW'(MAX_PEND));

  assign stall = iss_valid
               & (hazard
                  | (iss_long & at_lim)
                  | (st_q == S_FORCE));

  assign fire     = iss_valid & ~stall;
  assign lng_fire = fire & iss_long;

  // Clear first so that a same-cycle issue to the
  // committing register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (commit) begin
      busy_d[lu_rd] = 1'b0;
    end
    if (lng_fire && (iss_rd != 5'd0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pend_d = pend_q;
    if (lng_fire && !commit) begin
      if (!at_lim) begin
        pend_d = pend_q + PW'(1);
      end
    end else if (commit && !lng_fire) begin
      if (pend_q != '0) begin
        pend_d = pend_q - PW'(1);
      end
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    unique case (st_q)
      S_IDLE: begin
        if (denied) begin
          cnt_d = CW'(1);
          st_d  = (STARVE_LIM == 1) ? S_FORCE
                                    : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!denied) begin
          st_d  = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(STARVE_LIM)) begin
            st_d = S_FORCE;
          end
        end
      end
      S_FORCE: begin
        if (!denied) begin
          st_d  = S_IDLE;
          cnt_d = '0;
        end
      end
      default: begin
        st_d  = S_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      st_q   <= S_IDLE;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Testbench for rf_wb_sched: vector table, directed
// corner sequences and randomized run against a model.
module tb_rf_wb_sched;

  localparam int MAX_PEND   = 4;
  localparam int STARVE_LIM = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_ra, iss_rb, iss_rd;
  logic        iss_long;
  logic        stall;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_di;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_di;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_di;

  always #5 clk = ~clk;

  rf_wb_sched #(
    .MAX_PEND  (MAX_PEND),
    .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_ra   (iss_ra),
    .iss_rb   (iss_rb),
    .iss_rd   (iss_rd),
    .iss_long (iss_long),
    .stall    (stall),
    .pipe_we  (pipe_we),
    .pipe_rd  (pipe_rd),
    .pipe_di  (pipe_di),
    .lu_valid (lu_valid),
    .lu_rd    (lu_rd),
    .lu_di    (lu_di),
    .lu_ready (lu_ready),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_di    (rf_di)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: set of busy regs, outstanding count,
  // and length of the current run of denied lu cycles.
  bit          mbusy [32];
  int          mpend;
  int          mstreak;
  logic        m_stall, m_rdy, m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_di;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mpend   = 0;
    mstreak = 0;
  endtask

  task automatic settle();
    bit pact;
    #1;
    if (!rst) model_clear();
    pact  = pipe_we && (pipe_rd != 5'd0);
    m_rdy = !pact;
    m_we  = pact || lu_valid;
    m_rd  = pact ? pipe_rd : lu_rd;
    m_di  = pact ? pipe_di : lu_di;
    m_stall = iss_valid &&
      (mbusy[iss_ra] || mbusy[iss_rb] || mbusy[iss_rd]
       || (iss_long && mpend == MAX_PEND)
       || mstreak >= STARVE_LIM);
  endtask

  task automatic adv();
    bit cm, lf;
    if (!rst) begin
      model_clear();
    end else begin
      cm = lu_valid && m_rdy;
      lf = iss_valid && !m_stall && iss_long;
      if (cm) mbusy[lu_rd] = 1'b0;
      if (lf && iss_rd != 5'd0) mbusy[iss_rd] = 1'b1;
      if (lf && !cm) begin
        if (mpend < MAX_PEND) mpend++;
      end else if (cm && !lf) begin
        if (mpend > 0) mpend--;
      end
      if (lu_valid && !cm) begin
        if (mstreak < STARVE_LIM) mstreak++;
      end else begin
        mstreak = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    iss_valid = 0; iss_ra = 0; iss_rb = 0;
    iss_rd = 0; iss_long = 0;
    pipe_we = 0; pipe_rd = 0; pipe_di = 0;
    lu_valid = 0; lu_rd = 0; lu_di = 0;
  endtask

  task automatic iss(input logic v,
                     input logic [4:0] a, b, d,
                     input logic lg);
    iss_valid = v; iss_ra = a; iss_rb = b;
    iss_rd = d; iss_long = lg;
  endtask

  task automatic pip(input logic we,
                     input logic [4:0] d,
                     input logic [31:0] x);
    pipe_we = we; pipe_rd = d; pipe_di = x;
  endtask

  task automatic lu(input logic v,
                    input logic [4:0] d,
                    input logic [31:0] x);
    lu_valid = v; lu_rd = d; lu_di = x;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_in();
    settle();
    adv();
    rst = 1;
  endtask

  task automatic cyc_stall(input string nm,
                           input logic exp);
    settle();
    check(nm, stall, exp);
    adv();
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  ra, rb, rd;
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdi;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldi;
    logic        e_stall, e_rdy, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_di;
  } vec_t;

  vec_t tbl [6];

  logic [4:0] lq [$];
  bit         lu_hold;
  bit         hot;

  initial begin
    tbl[0] = '{0,0,0,0, 0,0,32'h0,
               0,0,32'h0, 0,1,0,0,32'h0};
    tbl[1] = '{0,0,0,0, 1,3,32'hAAAA,
               1,4,32'h5555, 0,0,1,3,32'hAAAA};
    tbl[2] = '{0,0,0,0, 1,0,32'h1234,
               1,4,32'h5555, 0,1,1,4,32'h5555};
    tbl[3] = '{0,0,0,0, 0,9,32'hFFFF,
               0,6,32'h77, 0,1,0,6,32'h77};
    tbl[4] = '{1,1,2,3, 1,31,32'hDEADBEEF,
               0,0,32'h0, 0,0,1,31,32'hDEADBEEF};
    tbl[5] = '{0,0,0,0, 0,0,32'h0,
               1,0,32'h42, 0,1,1,0,32'h42};

    // T1a: reset values while rst is low
    rst = 0;
    idle_in();
    iss(1, 5, 6, 7, 1);
    model_clear();
    settle();
    check("rst.stall", stall, 1'b0);
    check("rst.lu_ready", lu_ready, 1'b1);
    check("rst.rf_we", rf_we, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    idle_in();

    // Combinational port mux table
    for (int i = 0; i < 6; i++) begin
      iss(tbl[i].iv, tbl[i].ra, tbl[i].rb,
          tbl[i].rd, 1'b0);
      pip(tbl[i].pwe, tbl[i].prd, tbl[i].pdi);
      lu(tbl[i].lv, tbl[i].lrd, tbl[i].ldi);
      settle();
      check($sformatf("vec%0d.stall", i),
            stall, tbl[i].e_stall);
      check($sformatf("vec%0d.lu_ready", i),
            lu_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d.rf_we", i),
            rf_we, tbl[i].e_we);
      check($sformatf("vec%0d.rf_rd", i),
            rf_rd, tbl[i].e_rd);
      check($sformatf("vec%0d.rf_di", i),
            rf_di, tbl[i].e_di);
      adv();
      idle_in();
      settle();
      adv();
    end

    // T5: outstanding limit (count floor held at 0 above)
    for (int r = 1; r <= 4; r++) begin
      iss(1, 0, 0, 5'(r), 1);
      cyc_stall($sformatf("lim.iss%0d", r), 1'b0);
    end
    iss(1, 0, 0, 5, 1);
    cyc_stall("lim.fifth", 1'b1);
    iss(1, 7, 7, 7, 0);
    cyc_stall("lim.short", 1'b0);
    idle_in();
    lu(1, 1, 32'h11);
    settle();
    check("lim.commit_rdy", lu_ready, 1'b1);
    adv();
    idle_in();
    iss(1, 0, 0, 5, 1);
    cyc_stall("lim.after_commit", 1'b0);

    // T1b: async reset with busy regs / full count
    idle_in();
    iss(1, 2, 3, 4, 1);
    settle();
    check("rst.pre_busy", stall, 1'b1);
    #3;
    rst = 0;
    settle();
    check("rst.async_stall", stall, 1'b0);
    adv();
    rst = 1;
    iss(1, 2, 3, 4, 1);
    cyc_stall("rst.post", 1'b0);

    // T2: RAW/WAW and set-wins
    do_reset();
    iss(1, 1, 2, 5, 1);
    cyc_stall("raw.issue", 1'b0);
    iss(1, 5, 0, 6, 0);
    cyc_stall("raw.hold", 1'b1);
    iss(1, 0, 0, 5, 0);
    cyc_stall("waw.hold", 1'b1);
    iss(1, 5, 0, 6, 0);
    lu(1, 5, 32'h55);
    cyc_stall("raw.commit_cyc", 1'b1);
    lu(0, 0, 0);
    cyc_stall("raw.release", 1'b0);
    idle_in();
    iss(1, 0, 0, 7, 1);
    lu(1, 7, 32'h77);
    cyc_stall("setwin.issue", 1'b0);
    idle_in();
    iss(1, 7, 0, 1, 0);
    cyc_stall("setwin.busy", 1'b1);

    // T3/T4: arbitration and starvation
    do_reset();
    iss(1, 0, 0, 0, 0);
    pip(1, 3, 32'hAAAA);
    lu(1, 4, 32'hBBBB);
    settle();
    check("arb.rf_rd", rf_rd, 5'd3);
    check("arb.rf_di", rf_di, 32'hAAAA);
    check("arb.lu_ready", lu_ready, 1'b0);
    check("starve.c1", stall, 1'b0);
    adv();
    cyc_stall("starve.c2", 1'b0);
    cyc_stall("starve.c3", 1'b0);
    cyc_stall("starve.c4", 1'b1);
    pip(0, 0, 0);
    settle();
    check("arb.lu_rd", rf_rd, 5'd4);
    check("arb.lu_di", rf_di, 32'hBBBB);
    check("arb.lu_rdy2", lu_ready, 1'b1);
    check("starve.commit_cyc", stall, 1'b1);
    adv();
    lu(0, 0, 0);
    cyc_stall("starve.released", 1'b0);

    // Reset asserted while forcing
    pip(1, 3, 32'h1);
    lu(1, 4, 32'h2);
    for (int k = 0; k < 3; k++) begin
      settle();
      adv();
    end
    settle();
    check("force.pre_rst", stall, 1'b1);
    #3;
    rst = 0;
    settle();
    check("force.async_rst", stall, 1'b0);
    adv();
    rst = 1;

    // T6: x0 corners
    do_reset();
    iss(1, 0, 0, 0, 1);
    cyc_stall("x0.long_rd0", 1'b0);
    iss(1, 0, 0, 0, 0);
    cyc_stall("x0.not_busy", 1'b0);
    for (int r = 1; r <= 3; r++) begin
      iss(1, 0, 0, 5'(r), 1);
      cyc_stall($sformatf("x0.fill%0d", r), 1'b0);
    end
    iss(1, 0, 0, 8, 1);
    cyc_stall("x0.counted", 1'b1);
    idle_in();
    pip(1, 0, 32'hCCCC);
    lu(1, 9, 32'h99);
    settle();
    check("x0.pipe0_rdy", lu_ready, 1'b1);
    check("x0.pipe0_we", rf_we, 1'b1);
    check("x0.pipe0_rd", rf_rd, 5'd9);
    adv();
    idle_in();

    // Randomized run against the model
    do_reset();
    lq.delete();
    lu_hold = 0;
    hot = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) hot = !hot;
      if ($urandom_range(0, 499) == 0) begin
        rst = 0;
        lq.delete();
        lu_hold = 0;
      end else begin
        rst = 1;
      end
      iss_valid = 1'($urandom % 2);
      iss_ra    = 5'($urandom % 8);
      iss_rb    = 5'($urandom % 8);
      iss_rd    = 5'($urandom % 8);
      iss_long  = ($urandom % 5) < 2;
      pipe_we   = hot ? ($urandom % 4 != 0)
                      : ($urandom % 4 == 0);
      pipe_rd   = 5'($urandom % 8);
      pipe_di   = $urandom;
      if (!lu_hold && lq.size() > 0
          && $urandom % 3 != 0) begin
        lu_hold = 1;
        lu_rd   = lq[0];
        lu_di   = $urandom;
      end
      lu_valid = lu_hold;
      settle();
      check("rnd.stall", stall, m_stall);
      check("rnd.lu_ready", lu_ready, m_rdy);
      check("rnd.rf_we", rf_we, m_we);
      check("rnd.rf_rd", rf_rd, m_rd);
      check("rnd.rf_di", rf_di, m_di);
      if (rst) begin
        if (lu_valid && m_rdy) begin
          void'(lq.pop_front());
          lu_hold = 0;
        end
        if (iss_valid && !m_stall && iss_long)
          lq.push_back(iss_rd);
      end
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
